// File: rtl/ar429_pkg.sv
// Shared ARINC-429 definitions: transmitter states, word width and the
// half-bit timing formula used by the transmitter and its tick generator.
package ar429_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    GAP  = 2'd3
  } tx_state_e;

  localparam int WORD_W   = 32;
  localparam int HB_CNT_W = 16;

  // Clock cycles per half-bit; integer division, remainder is dropped.
  function automatic int hb_cycles(input int clk_hz, input int bit_rate);
    return clk_hz / (2 * bit_rate);
  endfunction

endpackage

// File: rtl/ar_tx_word_if.sv
// Caller-side bus of the ARINC-429 word transmitter.
// Handshake: st is a one-cycle strobe, taken only when busy is low (IDLE);
// a strobe while busy is high is dropped and answered by a one-cycle ovr.
// done marks the last gap cycle; busy falls on the following cycle.
interface ar_tx_word_if;
  import ar429_pkg::*;

  logic [30:0] din;
  logic        st;
  logic        TXP;
  logic        TXN;
  logic        busy;
  logic        done;
  logic        ovr;
  logic [5:0]  N_bit;
  tx_state_e   state;   // debug view of the transmitter FSM

  modport master (
    output din, st,
    input  TXP, TXN, busy, done, ovr, N_bit, state
  );

  modport slave (
    input  din, st,
    output TXP, TXN, busy, done, ovr, N_bit, state
  );

endinterface

// File: rtl/ar_tx_baud.sv
// Half-bit tick generator: 16-bit down counter loaded with HB-1, tick at 0.
module ar_tx_baud
  import ar429_pkg::*;
#(
  parameter int HB = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,   // start a fresh half-bit
  input  logic                en,     // count while a word or gap is active
  output logic                tick,   // last cycle of the current half-bit
  output logic [HB_CNT_W-1:0] cnt
);

  localparam logic [HB_CNT_W-1:0] HB_M1 = HB_CNT_W'(HB - 1);

  logic [HB_CNT_W-1:0] cnt_q, cnt_d;

  // Next count: reload on start or terminal count, park at zero when idle.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = HB_M1;
    end else if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      cnt_d = HB_M1;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = en && (cnt_q == '0);
  assign cnt  = cnt_q;

endmodule

// File: rtl/ar_tx_word.sv
// ARINC-429 word transmitter: 31 data bits LSB first plus odd parity,
// bipolar return-to-zero line coding, followed by a null gap.
module ar_tx_word
  import ar429_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BIT_RATE = 100_000,
  parameter int GAP_BITS = 4
) (
  input  logic           clk,
  input  logic           rst,
  ar_tx_word_if.slave    bus
);

  localparam int HB = hb_cycles(CLK_HZ, BIT_RATE);
  localparam logic [7:0] GAP_M1 = 8'(2 * GAP_BITS - 1);

  // Timing parameters the counters cannot represent are rejected at elaboration.
  if (HB < 2) begin : g_hb_min
    $error("ar_tx_word: half-bit must be at least 2 clock cycles");
  end
  if (HB > 65536) begin : g_hb_max
    $error("ar_tx_word: half-bit does not fit the 16-bit counter");
  end
  if (GAP_BITS < 1 || GAP_BITS > 128) begin : g_gap_rng
    $error("ar_tx_word: GAP_BITS must be 1..128");
  end

  tx_state_e            state_q, state_d;
  logic [WORD_W-1:0]    sh_q, sh_d;
  logic [5:0]           bit_q, bit_d;
  logic [7:0]           gap_q, gap_d;
  logic                 txp_q, txp_d;
  logic                 txn_q, txn_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ovr_q, ovr_d;
  logic                 accept;
  logic                 tick;
  logic [HB_CNT_W-1:0]  hb_cnt;

  assign accept = (state_q == IDLE) && bus.st;

  ar_tx_baud #(.HB(HB)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .en   (state_q != IDLE),
    .tick (tick),
    .cnt  (hb_cnt)
  );

  // FSM next state, shift register, bit index and registered line outputs.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    ovr_d   = bus.st && (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (bus.st) begin
          state_d = HIGH;
          sh_d    = {~^bus.din, bus.din};
          bit_d   = 6'd0;
        end
      end
      HIGH: begin
        if (tick) state_d = LOW;
      end
      LOW: begin
        if (tick) begin
          if (bit_q < 6'd31) begin
            state_d = HIGH;
            sh_d    = sh_q >> 1;
            bit_d   = bit_q + 6'd1;
          end else begin
            state_d = GAP;
            bit_d   = 6'd32;
            gap_d   = GAP_M1;
          end
        end
      end
      GAP: begin
        // done is registered, so it is raised one cycle ahead of the last gap cycle.
        if (gap_q == 8'd0 && hb_cnt == HB_CNT_W'(1)) done_d = 1'b1;
        if (tick) begin
          if (gap_q == 8'd0) begin
            state_d = IDLE;
            bit_d   = 6'd0;
          end else begin
            gap_d   = gap_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    txp_d  = (state_d == HIGH) &&  sh_d[0];
    txn_d  = (state_d == HIGH) && !sh_d[0];
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any word or gap in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      txp_q   <= 1'b0;
      txn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      txp_q   <= txp_d;
      txn_q   <= txn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.TXP   = txp_q;
  assign bus.TXN   = txn_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.ovr   = ovr_q;
  assign bus.N_bit = bit_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_ar_tx_word.sv
// Directed bench for ar_tx_word at HB=5 cycles, 4 gap bits.
module tb_ar_tx_word;
  import ar429_pkg::*;

  localparam int CLK_HZ   = 1000;
  localparam int BIT_RATE = 100;
  localparam int GAP_BITS = 4;
  localparam int HB       = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ar_tx_word_if bus ();

  ar_tx_word #(
    .CLK_HZ   (CLK_HZ),
    .BIT_RATE (BIT_RATE),
    .GAP_BITS (GAP_BITS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  // ---------------- line monitor ----------------
  int mon_both = 0, mon_bad_pulse = 0, mon_bad_null = 0, mon_pulses = 0;
  int run_len = HB;
  logic [1:0] run_lvl = 2'd0;   // 0 null, 1 TXP, 2 TXN
  logic [1:0] lvl;

  always @(negedge clk) begin
    if (bus.TXP && bus.TXN) mon_both++;
    lvl = bus.TXP ? 2'd1 : (bus.TXN ? 2'd2 : 2'd0);
    if (lvl == run_lvl) begin
      run_len++;
    end else begin
      if (run_lvl != 2'd0 && run_len != HB) mon_bad_pulse++;
      if (run_lvl != 2'd0 && lvl != 2'd0) mon_bad_null++;
      if (run_lvl == 2'd0 && lvl != 2'd0 && run_len < HB) mon_bad_null++;
      if (lvl != 2'd0) mon_pulses++;
      run_lvl = lvl;
      run_len = 1;
    end
  end

  // ---------------- driver tasks ----------------
  // Pulse st for one edge; returns at the negedge of the first busy cycle.
  task automatic start_word(input logic [30:0] d);
    bus.din = d;
    bus.st  = 1'b1;
    @(negedge clk);
    bus.st  = 1'b0;
    bus.din = ~d;   // later din changes must not reach the line
  endtask

  // Capture results for 362 cycles after acceptance.
  int cap_line_err, cap_nbit_err, cap_busy_err;
  int cap_done_k, cap_done_cnt, cap_ovr_cnt, cap_ovr_k1, cap_ovr_k2;
  logic [31:0] cap_word;
  tx_state_e cap_s1, cap_s6, cap_s321;

  task automatic capture(input logic [31:0] w, input int st_a, input int st_b, input int rst_at);
    cap_line_err = 0; cap_nbit_err = 0; cap_busy_err = 0;
    cap_done_k = 0; cap_done_cnt = 0; cap_ovr_cnt = 0; cap_ovr_k1 = 0; cap_ovr_k2 = 0;
    cap_word = '0;
    for (int k = 1; k <= 362; k++) begin
      logic alive, ep, en, eb;
      int enb;
      alive = (rst_at == 0) || (k <= rst_at);
      if (alive && k <= 320) begin
        ep  = ((k - 1) % 10 < 5) &&  w[(k - 1) / 10];
        en  = ((k - 1) % 10 < 5) && !w[(k - 1) / 10];
        enb = (k - 1) / 10;
      end else begin
        ep  = 1'b0;
        en  = 1'b0;
        enb = (alive && k <= 360) ? 32 : 0;
      end
      eb = alive && (k <= 360);
      if (bus.TXP !== ep || bus.TXN !== en) cap_line_err++;
      if (bus.N_bit !== 6'(enb)) cap_nbit_err++;
      if (bus.busy !== eb) cap_busy_err++;
      if (k <= 320 && (k - 1) % 10 == 0) cap_word[(k - 1) / 10] = (bus.TXP === 1'b1);
      if (bus.done === 1'b1) begin
        cap_done_cnt++;
        if (cap_done_k == 0) cap_done_k = k;
      end
      if (bus.ovr === 1'b1) begin
        cap_ovr_cnt++;
        if (cap_ovr_k1 == 0) cap_ovr_k1 = k;
        else if (cap_ovr_k2 == 0) cap_ovr_k2 = k;
      end
      if (k == 1)   cap_s1   = bus.state;
      if (k == 6)   cap_s6   = bus.state;
      if (k == 321) cap_s321 = bus.state;
      bus.st = (k == st_a) || (k == st_b);
      rst    = (k == rst_at);
      @(negedge clk);
    end
    bus.st = 1'b0;
    rst    = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.din = 31'h1234_5678;
    bus.st  = 1'b1;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({bus.TXP, bus.TXN} !== 2'b00) begin errors++; $display("FAIL reset_line got %b expected 00", {bus.TXP, bus.TXN}); end
    checks++; if ({bus.busy, bus.done, bus.ovr} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b expected 000", {bus.busy, bus.done, bus.ovr}); end
    checks++; if (bus.N_bit !== 6'd0 || bus.state !== IDLE) begin errors++; $display("FAIL reset_nbit_state got %0d/%0d expected 0/0", bus.N_bit, bus.state); end
    rst    = 1'b0;
    bus.st = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.ovr !== 1'b0) begin errors++; $display("FAIL st_in_reset got busy=%b ovr=%b expected 0 0", bus.busy, bus.ovr); end
  endtask

  task automatic test_zero_word();
    exp_q.push_back(32'h8000_0000);
    start_word(31'h0);
    capture(32'h8000_0000, 0, 0, 0);
    checks++; if (cap_word !== exp_q.pop_front()) begin errors++; $display("FAIL zero_word got %h expected 80000000", cap_word); end
    checks++; if (cap_line_err !== 0) begin errors++; $display("FAIL zero_line got %0d bad cycles expected 0", cap_line_err); end
    checks++; if (cap_nbit_err !== 0) begin errors++; $display("FAIL zero_nbit got %0d bad cycles expected 0", cap_nbit_err); end
    checks++; if (cap_busy_err !== 0) begin errors++; $display("FAIL zero_busy got %0d bad cycles expected 0", cap_busy_err); end
    checks++; if (cap_done_k !== 360 || cap_done_cnt !== 1) begin errors++; $display("FAIL zero_done got k=%0d n=%0d expected k=360 n=1", cap_done_k, cap_done_cnt); end
    checks++; if (cap_ovr_cnt !== 0) begin errors++; $display("FAIL zero_ovr got %0d expected 0", cap_ovr_cnt); end
    checks++; if (cap_s1 !== HIGH || cap_s6 !== LOW || cap_s321 !== GAP) begin errors++; $display("FAIL zero_states got %0d %0d %0d expected 1 2 3", cap_s1, cap_s6, cap_s321); end
  endtask

  task automatic test_ones_word();
    exp_q.push_back(32'h7FFF_FFFF);
    start_word(31'h7FFF_FFFF);
    capture(32'h7FFF_FFFF, 0, 0, 0);
    checks++; if (cap_word !== exp_q.pop_front()) begin errors++; $display("FAIL ones_word got %h expected 7fffffff", cap_word); end
    checks++; if (cap_line_err !== 0) begin errors++; $display("FAIL ones_line got %0d bad cycles expected 0", cap_line_err); end
    checks++; if (cap_done_k !== 360 || cap_busy_err !== 0) begin errors++; $display("FAIL ones_done got k=%0d busy_err=%0d expected 360 0", cap_done_k, cap_busy_err); end
  endtask

  task automatic test_label_word();
    exp_q.push_back(32'h0000_0083);
    start_word(31'h0000_0083);
    capture(32'h0000_0083, 0, 0, 0);
    checks++; if (cap_word !== exp_q.pop_front()) begin errors++; $display("FAIL label_word got %h expected 00000083", cap_word); end
    checks++; if (cap_line_err !== 0) begin errors++; $display("FAIL label_line got %0d bad cycles expected 0", cap_line_err); end
    checks++; if (cap_nbit_err !== 0) begin errors++; $display("FAIL label_nbit got %0d bad cycles expected 0", cap_nbit_err); end
  endtask

  task automatic test_overrun();
    exp_q.push_back(32'h2AAA_5555);
    start_word(31'h2AAA_5555);
    capture(32'h2AAA_5555, 100, 360, 0);
    checks++; if (cap_word !== exp_q.pop_front()) begin errors++; $display("FAIL ovr_word got %h expected 2aaa5555", cap_word); end
    checks++; if (cap_line_err !== 0) begin errors++; $display("FAIL ovr_line got %0d bad cycles expected 0", cap_line_err); end
    checks++; if (cap_ovr_cnt !== 2 || cap_ovr_k1 !== 101 || cap_ovr_k2 !== 361) begin errors++; $display("FAIL ovr_pulses got n=%0d at %0d,%0d expected n=2 at 101,361", cap_ovr_cnt, cap_ovr_k1, cap_ovr_k2); end
    checks++; if (cap_done_k !== 360 || cap_busy_err !== 0) begin errors++; $display("FAIL ovr_done got k=%0d busy_err=%0d expected 360 0", cap_done_k, cap_busy_err); end
  endtask

  task automatic test_rst_mid_word();
    start_word(31'h1234_5678);
    capture(32'h1234_5678, 0, 0, 157);
    checks++; if (cap_line_err !== 0) begin errors++; $display("FAIL rst_line got %0d bad cycles expected 0", cap_line_err); end
    checks++; if (cap_busy_err !== 0) begin errors++; $display("FAIL rst_busy got %0d bad cycles expected 0", cap_busy_err); end
    checks++; if (cap_done_cnt !== 0) begin errors++; $display("FAIL rst_done got %0d pulses expected 0", cap_done_cnt); end
    checks++; if (cap_word[15:0] !== 16'h5678) begin errors++; $display("FAIL rst_partial got %h expected 5678", cap_word[15:0]); end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(32'h8000_0005);
    start_word(31'h0000_0005);
    capture(32'h8000_0005, 0, 0, 0);
    checks++; if (cap_word !== exp_q.pop_front()) begin errors++; $display("FAIL b2b_word got %h expected 80000005", cap_word); end
    checks++; if (cap_line_err !== 0 || cap_busy_err !== 0) begin errors++; $display("FAIL b2b_line got line_err=%0d busy_err=%0d expected 0 0", cap_line_err, cap_busy_err); end
    checks++; if (cap_done_k !== 360 || cap_done_cnt !== 1) begin errors++; $display("FAIL b2b_done got k=%0d n=%0d expected k=360 n=1", cap_done_k, cap_done_cnt); end
  endtask

  task automatic test_line_rules();
    checks++; if (mon_both !== 0) begin errors++; $display("FAIL both_high got %0d cycles expected 0", mon_both); end
    checks++; if (mon_bad_pulse !== 0) begin errors++; $display("FAIL pulse_width got %0d bad pulses expected 0", mon_bad_pulse); end
    checks++; if (mon_bad_null !== 0) begin errors++; $display("FAIL null_width got %0d short nulls expected 0", mon_bad_null); end
    checks++; if (mon_pulses !== 176) begin errors++; $display("FAIL pulse_count got %0d expected 176", mon_pulses); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.din = '0;
    bus.st  = 1'b0;
    test_reset();
    test_zero_word();
    test_ones_word();
    test_label_word();
    test_overrun();
    test_rst_mid_word();
    test_back_to_back();
    test_line_rules();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
